// File: rtl/a2d_spi_resp.sv
// SPI mode-0 responder standing in for an 8-channel 12-bit serial ADC.
// Latches the channel field of each frame and returns that channel's sample in the following frame.
module a2d_spi_resp #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int CH_LSB     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] ch_data,
    output logic [2:0]           chnnl,
    output logic                 frame_cmplt,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    logic [2:0]              ss_sync;
    logic [2:0]              sclk_sync;
    logic [2:0]              mosi_sync;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    start_pend;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    // [1:0] are the synchronizer stages, [2] is the edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
        end else begin
            ss_sync   <= {ss_sync[1:0], SS_n};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[1:0], MOSI};
        end
    end

    always_comb begin
        ss_fall   = ss_sync[2] & ~ss_sync[1];
        ss_rise   = ~ss_sync[2] & ss_sync[1];
        sclk_rise = ~sclk_sync[2] & sclk_sync[1];
        sclk_fall = sclk_sync[2] & ~sclk_sync[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            start_pend  <= 1'b0;
            MISO        <= 1'b0;
            chnnl       <= '0;
            frame_cmplt <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_cmplt <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall || start_pend) begin
                        tx_shift   <= {{(FRAME_BITS-DATA_BITS){1'b0}}, ch_data};
                        bit_cnt    <= '0;
                        start_pend <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync[2]};
                        if (bit_cnt != '1)
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                    // A fall before any rise is an idle-high glitch, not a data edge
                    if (sclk_fall && bit_cnt != '0) begin
                        tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                        MISO     <= tx_shift[FRAME_BITS-2];
                    end
                    if (ss_rise) begin
                        MISO  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A fall seen here would be lost as an edge pulse; hold it for IDLE
                    start_pend <= ss_fall;
                    state      <= IDLE;
                    if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                        chnnl       <= rx_shift[CH_LSB+2:CH_LSB];
                        frame_cmplt <= 1'b1;
                        frame_cnt   <= frame_cnt + 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: drives a mode-0 SPI master and a channel sample table.
module tb_a2d_spi_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] ch_data;
    logic [2:0]  chnnl;
    logic        frame_cmplt;
    logic        frame_err;
    logic [15:0] frame_cnt;

    logic [11:0] chmem [8];
    int          nchecks = 0;
    int          nerrors = 0;
    int          prev_ch;
    logic [15:0] exp_cnt;

    a2d_spi_resp #(
        .FRAME_BITS (16),
        .DATA_BITS  (12),
        .CH_LSB     (11)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SS_n        (SS_n),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .ch_data     (ch_data),
        .chnnl       (chnnl),
        .frame_cmplt (frame_cmplt),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    assign ch_data = chmem[chnnl];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] word, input int nbits, input int mod_at,
                             output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == mod_at)
                chmem[prev_ch] = ~chmem[prev_ch];
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            repeat (8) @(negedge clk);
            rx   = {rx[14:0], MISO};
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [15:0] word, input int nbits, input int mod_at,
                             output logic [15:0] rx, output int ncmp, output int nerr,
                             output int first_at, output logic [2:0] ch_at);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (10) @(negedge clk);
        send_bits(word, nbits, mod_at, rx);
        repeat (8) @(negedge clk);
        SS_n     = 1'b1;
        ncmp     = 0;
        nerr     = 0;
        first_at = 0;
        ch_at    = chnnl;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (frame_cmplt === 1'b1) begin
                ncmp++;
                if (first_at == 0) first_at = c;
                ch_at = chnnl;
            end
            if (frame_err === 1'b1) begin
                nerr++;
                if (first_at == 0) first_at = c;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic good_frame(input logic [2:0] ch, input int mod_at);
        logic [15:0] rx, exp_rx;
        int          ncmp, nerr, first_at;
        logic [2:0]  ch_at;
        exp_rx = {4'h0, chmem[prev_ch]};
        run_frame({2'b00, ch, 11'b0}, 16, mod_at, rx, ncmp, nerr, first_at, ch_at);
        exp_cnt = exp_cnt + 16'd1;
        check("miso_word", rx, exp_rx);
        check("cmplt_pulses", ncmp, 1);
        check("err_pulses", nerr, 0);
        check("pulse_latency", first_at, 4);
        check("chnnl_at_pulse", ch_at, ch);
        check("frame_cnt", frame_cnt, exp_cnt);
        prev_ch = ch;
    endtask

    task automatic bad_frame(input logic [2:0] ch, input int nbits);
        logic [15:0] rx;
        int          ncmp, nerr, first_at;
        logic [2:0]  ch_at;
        run_frame({2'b00, ch, 11'b0}, nbits, -1, rx, ncmp, nerr, first_at, ch_at);
        check("bad_err_pulses", nerr, 1);
        check("bad_cmplt_pulses", ncmp, 0);
        check("bad_latency", first_at, 4);
        check("bad_chnnl", chnnl, prev_ch);
        check("bad_frame_cnt", frame_cnt, exp_cnt);
    endtask

    initial begin
        int spur;
        logic [15:0] rx;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b0;
        MOSI  = 1'b0;
        for (int i = 0; i < 8; i++) chmem[i] = 12'h000;
        chmem[0] = 12'hA5C;
        chmem[3] = 12'h3F1;
        prev_ch = 0;
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        check("rst_miso", MISO, 0);
        check("rst_chnnl", chnnl, 0);
        check("rst_cmplt", frame_cmplt, 0);
        check("rst_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Frame 1 returns ch0, frame 2 returns ch3
        good_frame(3'd3, -1);
        good_frame(3'd0, -1);

        chmem[0] = 12'h0A1; chmem[1] = 12'h1B2; chmem[2] = 12'h2C3; chmem[3] = 12'h3D4;
        chmem[4] = 12'h4E5; chmem[5] = 12'h5F6; chmem[6] = 12'h607; chmem[7] = 12'h718;
        for (int k = 1; k < 8; k++) good_frame(3'(k), -1);
        good_frame(3'd0, -1);

        // Short frame, recovery, long frame
        bad_frame(3'd5, 10);
        good_frame(3'd2, -1);
        bad_frame(3'd6, 17);

        // SCLK/MOSI activity with SS_n high
        spur = 0;
        for (int c = 0; c < 96; c++) begin
            if (c % 8 == 0) begin
                SCLK = ~SCLK;
                MOSI = 1'($urandom);
            end
            @(negedge clk);
            if (frame_cmplt === 1'b1 || frame_err === 1'b1) spur++;
        end
        check("idle_spurious_pulses", spur, 0);
        check("idle_chnnl", chnnl, prev_ch);
        check("idle_frame_cnt", frame_cnt, exp_cnt);
        check("idle_miso", MISO, 0);

        // ch_data flips after bit 5; returned word is the load-time value
        good_frame(3'd5, 5);

        // Counter wrap
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        check("cnt_preload", frame_cnt, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        good_frame(3'd6, -1);
        good_frame(3'd1, -1);

        // Reset in the middle of a frame
        for (int i = 0; i < 8; i++) chmem[i] = 12'hFFF;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (10) @(negedge clk);
        send_bits({2'b00, 3'd7, 11'b0}, 7, -1, rx);
        repeat (8) @(negedge clk);
        check("miso_before_rst", MISO, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", MISO, 0);
        check("midrst_chnnl", chnnl, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        SS_n = 1'b1;
        spur = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (frame_cmplt === 1'b1 || frame_err === 1'b1) spur++;
        end
        check("midrst_pulses", spur, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        prev_ch = 0;
        exp_cnt = '0;
        chmem[0] = 12'h6B9; chmem[4] = 12'h222;
        good_frame(3'd4, -1);
        good_frame(3'd0, -1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
